kb_ascii_fifo: RTL and testbench
================================

Name: kb_ascii_fifo

Overview:
Downstream consumer of the PS/2 receiver byte stream (byte strobe plus byte). Decodes scan-code set 2 prefixes (E0 extended, F0 break) and tracks left/right shift and caps-lock. Translates make codes of printable and control keys to 7-bit ASCII. Buffers the characters in a small FIFO with a valid/ready pop interface, for a future text or UART sink.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
AW, 3, pointer width = log2(DEPTH)

Ports:
clk  in  1  system clock
i_arst_n  in  1  reset, asynchronous assert, active-low
i_byte_en  in  1  one-cycle strobe, i_byte valid
i_byte  in  8  received PS/2 byte
i_ready  in  1  consumer pops head when o_valid & i_ready
o_valid  out  1  FIFO non-empty
o_char  out  7  ASCII at FIFO head; 0 when empty
o_shift  out  1  left or right shift held
o_capslock  out  1  caps-lock toggle state
o_overflow  out  1  sticky: a character was dropped because the FIFO was full
o_count  out  AW+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (i_arst_n=0, any time, asynchronous): decoder state IDLE; shift flags, caps, caps_held, overflow cleared; FIFO pointers 0; all outputs 0. Any partial prefix sequence is discarded.
- The decoder advances only on cycles with i_byte_en=1.
- Decoder FSM:
  - IDLE: E0->EXT, F0->BRK, else make(code), stay IDLE.
  - EXT: F0->EXT_BRK, else ext_make(code)->IDLE.
  - BRK: break(code)->IDLE.
  - EXT_BRK: ext_break->IDLE; no effect.
  - Bytes AA, FA, EE, FE, 00, FF in IDLE are ignored.
- make: 12 sets lshift, 59 sets rshift.
  - 58 toggles caps only if caps_held=0, then sets caps_held (typematic repeat does not re-toggle).
  - Table codes push one character; other codes are ignored.
- break: 12/59 clear the respective shift flag; 58 clears caps_held.
- ext_make: 5A (keypad enter) pushes 0x0D; all others are ignored.
- Letters (uppercase shown):
  - 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M
  - 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z
  - Uppercase when shift XOR caps, else lowercase (+0x20).
- Digits: 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9, 45 0.
  - With shift held these become ! @ # $ % ^ & * ( ); caps has no effect.
- Others, unaffected by shift/caps: 29 0x20, 5A 0x0D, 66 0x08, 0D 0x09, 76 0x1B.
- Latency: the translated character is written to the FIFO in the cycle after the i_byte_en of the make byte. With the FIFO previously empty, o_valid=1 two cycles after that strobe.
- o_shift, o_capslock update one cycle after the relevant strobe.
- FIFO, registered pointers with an extra wrap bit:
  - Pop on o_valid & i_ready. i_ready while empty has no effect.
  - Push when full and no pop in the same cycle: character dropped, o_overflow set and held until reset.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle when count=1: new character becomes head, o_valid stays 1.
  - Pointers wrap modulo DEPTH; o_count = wr - rd on AW+1 bits.
- o_char is combinational from the head entry; 0 whenever o_valid=0.

Test Plan:
- Bytes 1C, F0 1C -> exactly one char 0x61 'a'; o_valid 2 cycles after the 1C strobe; o_count=1.
- 12, 1C, F0 12, 1C -> 'A' then 'a'; o_shift rises after 12, falls after the F0 12 sequence.
- 58, 58, F0 58, 1C, 58, F0 58, 12, 1C -> o_capslock toggles once per press; output 'A' then, with caps off and shift held, 'A'.
- Caps on with shift held, 1E -> '@'; release shift, 1E -> '2'; E0 5A -> 0x0D; E0 75 and E0 F0 75 -> no push.
- DEPTH=8, i_ready=0, nine make codes -> o_count=8, o_overflow=1, first 8 chars intact in order.
- Full FIFO with simultaneous push and pop -> no overflow, count stays 8.
- Assert i_arst_n=0 mid-sequence (after E0, with shift held, count=3) -> all outputs 0 immediately.
- Same case, next byte 1C after release -> 'a' (prefix and shift discarded).

Source files
------------

// File: rtl/kb_ascii_fifo.sv
// PS/2 scan-code set 2 decoder with shift/caps tracking, ASCII translation
// and a small valid/ready character FIFO.
module kb_ascii_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          i_arst_n,
    input  logic          i_byte_en,
    input  logic [7:0]    i_byte,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [6:0]    o_char,
    output logic          o_shift,
    output logic          o_capslock,
    output logic          o_overflow,
    output logic [AW:0]   o_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    state_t      state_reg, state_next;
    logic        lshift_reg, lshift_next;
    logic        rshift_reg, rshift_next;
    logic        caps_reg, caps_next;
    logic        caps_held_reg, caps_held_next;
    logic        push_reg, push_next;
    logic [6:0]  push_char_reg, push_char_next;
    logic        overflow_reg;
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    logic [6:0]  mem [DEPTH];

    logic [AW:0] count;
    logic        full, pop, wr_en;

    // Returns 0 for codes without a character; no table entry maps to 0.
    function automatic logic [6:0] translate(input logic [7:0] code,
                                             input logic shift,
                                             input logic caps);
        logic [6:0] ch;
        ch = 7'h00;
        case (code)
            8'h1C: ch = 7'h41;  8'h32: ch = 7'h42;  8'h21: ch = 7'h43;
            8'h23: ch = 7'h44;  8'h24: ch = 7'h45;  8'h2B: ch = 7'h46;
            8'h34: ch = 7'h47;  8'h33: ch = 7'h48;  8'h43: ch = 7'h49;
            8'h3B: ch = 7'h4A;  8'h42: ch = 7'h4B;  8'h4B: ch = 7'h4C;
            8'h3A: ch = 7'h4D;  8'h31: ch = 7'h4E;  8'h44: ch = 7'h4F;
            8'h4D: ch = 7'h50;  8'h15: ch = 7'h51;  8'h2D: ch = 7'h52;
            8'h1B: ch = 7'h53;  8'h2C: ch = 7'h54;  8'h3C: ch = 7'h55;
            8'h2A: ch = 7'h56;  8'h1D: ch = 7'h57;  8'h22: ch = 7'h58;
            8'h35: ch = 7'h59;  8'h1A: ch = 7'h5A;
            8'h16: ch = shift ? 7'h21 : 7'h31;
            8'h1E: ch = shift ? 7'h40 : 7'h32;
            8'h26: ch = shift ? 7'h23 : 7'h33;
            8'h25: ch = shift ? 7'h24 : 7'h34;
            8'h2E: ch = shift ? 7'h25 : 7'h35;
            8'h36: ch = shift ? 7'h5E : 7'h36;
            8'h3D: ch = shift ? 7'h26 : 7'h37;
            8'h3E: ch = shift ? 7'h2A : 7'h38;
            8'h46: ch = shift ? 7'h28 : 7'h39;
            8'h45: ch = shift ? 7'h29 : 7'h30;
            8'h29: ch = 7'h20;  8'h5A: ch = 7'h0D;  8'h66: ch = 7'h08;
            8'h0D: ch = 7'h09;  8'h76: ch = 7'h1B;
            default: ch = 7'h00;
        endcase
        // Only letters land in 'A'..'Z'; shifted digit symbols stay outside it.
        if (ch >= 7'h41 && ch <= 7'h5A && !(shift ^ caps))
            ch = ch + 7'h20;
        return ch;
    endfunction

    always_comb begin
        state_next     = state_reg;
        lshift_next    = lshift_reg;
        rshift_next    = rshift_reg;
        caps_next      = caps_reg;
        caps_held_next = caps_held_reg;
        push_next      = 1'b0;
        push_char_next = 7'h00;
        if (i_byte_en) begin
            case (state_reg)
                ST_IDLE: begin
                    case (i_byte)
                        8'hE0: state_next = ST_EXT;
                        8'hF0: state_next = ST_BRK;
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                        8'h12: lshift_next = 1'b1;
                        8'h59: rshift_next = 1'b1;
                        8'h58: begin
                            // Typematic repeats arrive while held and must not re-toggle.
                            if (!caps_held_reg)
                                caps_next = ~caps_reg;
                            caps_held_next = 1'b1;
                        end
                        default: begin
                            push_char_next = translate(i_byte, lshift_reg | rshift_reg, caps_reg);
                            push_next      = (push_char_next != 7'h00);
                        end
                    endcase
                end
                ST_EXT: begin
                    if (i_byte == 8'hF0) begin
                        state_next = ST_EXT_BRK;
                    end else begin
                        state_next = ST_IDLE;
                        if (i_byte == 8'h5A) begin
                            push_next      = 1'b1;
                            push_char_next = 7'h0D;
                        end
                    end
                end
                ST_BRK: begin
                    state_next = ST_IDLE;
                    if (i_byte == 8'h12) lshift_next = 1'b0;
                    if (i_byte == 8'h59) rshift_next = 1'b0;
                    if (i_byte == 8'h58) caps_held_next = 1'b0;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign count = wr_ptr_reg - rd_ptr_reg;
    assign full  = (count == FULL_COUNT);
    assign pop   = o_valid & i_ready;
    assign wr_en = push_reg & (!full | pop);

    always_ff @(posedge clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_reg     <= ST_IDLE;
            lshift_reg    <= 1'b0;
            rshift_reg    <= 1'b0;
            caps_reg      <= 1'b0;
            caps_held_reg <= 1'b0;
            push_reg      <= 1'b0;
            push_char_reg <= 7'h00;
            overflow_reg  <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            lshift_reg    <= lshift_next;
            rshift_reg    <= rshift_next;
            caps_reg      <= caps_next;
            caps_held_reg <= caps_held_next;
            push_reg      <= push_next;
            push_char_reg <= push_char_next;
            if (push_reg && full && !pop)
                overflow_reg <= 1'b1;
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg[AW-1:0]] <= push_char_reg;
    end

    assign o_valid    = (count != '0);
    assign o_char     = o_valid ? mem[rd_ptr_reg[AW-1:0]] : 7'h00;
    assign o_shift    = lshift_reg | rshift_reg;
    assign o_capslock = caps_reg;
    assign o_overflow = overflow_reg;
    assign o_count    = count;

endmodule

// File: tb/tb_kb_ascii_fifo.sv
// Directed bench for kb_ascii_fifo: scan-code sequences in, expected ASCII
// queued at stimulus time and compared as the FIFO is popped.
module tb_kb_ascii_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          i_arst_n = 1'b0;
    logic          i_byte_en = 1'b0;
    logic [7:0]    i_byte = 8'h00;
    logic          i_ready = 1'b0;
    logic          o_valid;
    logic [6:0]    o_char;
    logic          o_shift;
    logic          o_capslock;
    logic          o_overflow;
    logic [AW:0]   o_count;

    int checks = 0;
    int errors = 0;
    logic [6:0] expq [$];
    logic [6:0] head_exp;

    kb_ascii_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .i_arst_n   (i_arst_n),
        .i_byte_en  (i_byte_en),
        .i_byte     (i_byte),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_char     (o_char),
        .o_shift    (o_shift),
        .o_capslock (o_capslock),
        .o_overflow (o_overflow),
        .o_count    (o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        i_byte_en = 1'b1;
        i_byte    = b;
        @(posedge clk);
        #1;
        i_byte_en = 1'b0;
        i_byte    = 8'h00;
    endtask

    task automatic key(input logic [7:0] b, input logic [6:0] c);
        send(b);
        expq.push_back(c);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        logic [31:0] exp;
        i_ready = 1'b1;
        for (int i = 0; i < DEPTH + 4 && o_valid; i++) begin
            exp = (expq.size() != 0) ? 32'(expq.pop_front()) : 32'hFF;
            chk("pop_char", 32'(o_char), exp);
            $display("pop char=%02h expected=%02h count=%0d", o_char, exp[6:0], o_count);
            @(posedge clk);
            #1;
        end
        i_ready = 1'b0;
        chk("drained_valid", 32'(o_valid), 32'd0);
        chk("queue_empty", 32'(expq.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_char"}, 32'(o_char), 32'd0);
        chk({tag, "_shift"}, 32'(o_shift), 32'd0);
        chk({tag, "_caps"}, 32'(o_capslock), 32'd0);
        chk({tag, "_ovf"}, 32'(o_overflow), 32'd0);
        chk({tag, "_count"}, 32'(o_count), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        i_arst_n = 1'b1;
        idle(1);

        // Single make + break, latency
        key(8'h1C, 7'h61);
        chk("lat_valid_early", 32'(o_valid), 32'd0);
        idle(1);
        chk("lat_valid", 32'(o_valid), 32'd1);
        chk("lat_count", 32'(o_count), 32'd1);
        send(8'hF0);
        send(8'h1C);
        idle(2);
        chk("break_no_push", 32'(o_count), 32'd1);
        drain();

        // Shift
        send(8'h12);
        chk("shift_rise", 32'(o_shift), 32'd1);
        key(8'h1C, 7'h41);
        send(8'hF0);
        send(8'h12);
        chk("shift_fall", 32'(o_shift), 32'd0);
        key(8'h1C, 7'h61);
        idle(2);
        drain();

        // Caps lock with typematic repeat
        send(8'h58);
        chk("caps_on", 32'(o_capslock), 32'd1);
        send(8'h58);
        chk("caps_repeat", 32'(o_capslock), 32'd1);
        send(8'hF0);
        send(8'h58);
        key(8'h1C, 7'h41);
        send(8'h58);
        chk("caps_off", 32'(o_capslock), 32'd0);
        send(8'hF0);
        send(8'h58);
        send(8'h12);
        key(8'h1C, 7'h41);
        idle(2);
        drain();

        // Caps on + shift held digits, extended codes
        send(8'h58);
        send(8'hF0);
        send(8'h58);
        chk("caps_on2", 32'(o_capslock), 32'd1);
        key(8'h1E, 7'h40);
        send(8'hF0);
        send(8'h12);
        key(8'h1E, 7'h32);
        send(8'hE0);
        key(8'h5A, 7'h0D);
        send(8'hE0);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        idle(2);
        chk("ext_count", 32'(o_count), 32'd3);
        drain();

        // Fill to full (caps on -> uppercase)
        key(8'h1C, 7'h41); key(8'h32, 7'h42); key(8'h21, 7'h43); key(8'h23, 7'h44);
        key(8'h24, 7'h45); key(8'h2B, 7'h46); key(8'h34, 7'h47); key(8'h33, 7'h48);
        idle(2);
        chk("full_count", 32'(o_count), 32'd8);
        chk("full_no_ovf", 32'(o_overflow), 32'd0);
        // Push lands on the same edge as a pop
        send(8'h3B);
        i_ready  = 1'b1;
        head_exp = expq.pop_front();
        chk("simul_head", 32'(o_char), 32'(head_exp));
        expq.push_back(7'h4A);
        idle(1);
        i_ready = 1'b0;
        chk("simul_count", 32'(o_count), 32'd8);
        chk("simul_no_ovf", 32'(o_overflow), 32'd0);
        send(8'h42);
        idle(2);
        chk("ovf_count", 32'(o_count), 32'd8);
        chk("ovf_set", 32'(o_overflow), 32'd1);
        drain();
        chk("ovf_sticky", 32'(o_overflow), 32'd1);

        // Asynchronous reset mid-sequence
        send(8'h12);
        key(8'h1C, 7'h61); key(8'h1C, 7'h61); key(8'h1C, 7'h61);
        send(8'hE0);
        idle(2);
        chk("pre_rst_count", 32'(o_count), 32'd3);
        chk("pre_rst_shift", 32'(o_shift), 32'd1);
        chk("pre_rst_caps", 32'(o_capslock), 32'd1);
        i_arst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        expq.delete();
        @(negedge clk);
        i_arst_n = 1'b1;
        idle(1);
        key(8'h1C, 7'h61);
        idle(2);
        chk("post_rst_count", 32'(o_count), 32'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
